// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared channel state encoding and data_in field offsets for cfg_pulse_bank
package cfg_pkg;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } chan_state_e;

  // data_in layout: bit SET_BIT selects start/retrigger (1) or abort (0),
  // length field starts at LEN_LSB
  localparam int SET_BIT = 0;
  localparam int LEN_LSB = 1;

endpackage

// File: rtl/cfg_pulse_chan.sv
// rtl/cfg_pulse_chan.sv - single pulse channel: IDLE/ACTIVE FSM with saturating down-counter
module cfg_pulse_chan
  import cfg_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_hit,
  input  logic                 i_set,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_pulse,
  output logic [LEN_WIDTH-1:0] o_count
);

  chan_state_e          r_state;
  chan_state_e          w_state_nxt;
  logic [LEN_WIDTH-1:0] r_count;
  logic [LEN_WIDTH-1:0] w_count_nxt;

  // State and remaining-count registers; reset drops any pulse in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: a write wins over the countdown (start/retrigger or abort),
  // otherwise an active channel counts down and retires after its count-0 cycle
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (i_hit) begin
      if (i_set) begin
        w_state_nxt = CH_ACTIVE;
        w_count_nxt = i_len;
      end else begin
        w_state_nxt = CH_IDLE;
        w_count_nxt = '0;
      end
    end else begin
      case (r_state)
        CH_ACTIVE: begin
          if (r_count == '0) begin
            w_state_nxt = CH_IDLE;
          end else begin
            w_count_nxt = r_count - LEN_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt = CH_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign o_pulse = (r_state == CH_ACTIVE);
  assign o_count = r_count;

endmodule

// File: rtl/cfg_pulse_bank.sv
// rtl/cfg_pulse_bank.sv - bank of register-triggered pulse channels; CFG_PULSE_BANK_READBACK_EN adds the read path
module cfg_pulse_bank
  import cfg_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int REG_BASE       = 0,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_en,
  input  logic [REG_ADDR_WIDTH-1:0] addr_in,
  input  logic [LEN_WIDTH:0]        data_in,
  input  logic                      rd_en,
  output logic [LEN_WIDTH:0]        rd_data,
  output logic                      rd_valid,
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [NUM_CH-1:0]         busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One extra bit so REG_BASE+NUM_CH at the top of the address space does not wrap
  localparam logic [REG_ADDR_WIDTH:0] LP_BASE = (REG_ADDR_WIDTH+1)'(REG_BASE);
  localparam logic [REG_ADDR_WIDTH:0] LP_END  = (REG_ADDR_WIDTH+1)'(REG_BASE + NUM_CH);

  logic [REG_ADDR_WIDTH:0]            w_addr_ext;
  logic [REG_ADDR_WIDTH:0]            w_off;
  logic                               w_in_range;
  logic [IDX_W-1:0]                   w_idx;
  logic [NUM_CH-1:0]                  w_hit;
  logic [NUM_CH-1:0]                  w_pulse;
  logic [NUM_CH-1:0][LEN_WIDTH-1:0]   w_count;

  assign w_addr_ext = {1'b0, addr_in};
  assign w_off      = w_addr_ext - LP_BASE;
  assign w_in_range = (w_addr_ext >= LP_BASE) && (w_addr_ext < LP_END);
  assign w_idx      = IDX_W'(w_off);

  // Address decode: at most one channel is hit per cycle
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      assign w_hit[g] = write_en && w_in_range && (w_idx == IDX_W'(g));

      cfg_pulse_chan #(
        .LEN_WIDTH (LEN_WIDTH)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hit   (w_hit[g]),
        .i_set   (data_in[SET_BIT]),
        .i_len   (data_in[LEN_LSB +: LEN_WIDTH]),
        .o_pulse (w_pulse[g]),
        .o_count (w_count[g])
      );
    end
  endgenerate

  assign pulse_out = w_pulse;
  assign busy      = w_pulse;

`ifdef CFG_PULSE_BANK_READBACK_EN
  logic [LEN_WIDTH:0] r_rd_data;
  logic               r_rd_valid;

  // Registered read mux; samples channel state before any same-cycle write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en && w_in_range) begin
        r_rd_data <= {w_count[w_idx], w_pulse[w_idx]};
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`else
  logic w_unused_rd;

  assign w_unused_rd = rd_en ^ (^w_count);
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_pulse_bank.sv
// tb/tb_cfg_pulse_bank.sv - scoreboard bench for cfg_pulse_bank (NUM_CH=4, REG_BASE=0x10)
module tb_cfg_pulse_bank;

  localparam int NUM_CH = 4;
  localparam int AW     = 8;
  localparam int LW     = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_en;
  logic [AW-1:0] addr_in;
  logic [LW:0]   data_in;
  logic          rd_en;
  logic [LW:0]   rd_data;
  logic          rd_valid;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NUM_CH-1:0] sb_pulse[$];
  logic [LW+1:0]     sb_rd[$];

  cfg_pulse_bank #(
    .NUM_CH         (NUM_CH),
    .REG_BASE       ('h10),
    .REG_ADDR_WIDTH (AW),
    .LEN_WIDTH      (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en  (write_en),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .pulse_out (pulse_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en = 1'b0;
    rd_en    = 1'b0;
    addr_in  = '0;
    data_in  = '0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic set);
    write_en = 1'b1;
    addr_in  = a;
    data_in  = {len, set};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_out !== 4'b0000) $display("FAIL reset_pulse: pulse_out=%b expected 0000", pulse_out);
    else n_pass++;
    n_checks++;
    if (busy !== 4'b0000) $display("FAIL reset_busy: busy=%b expected 0000", busy);
    else n_pass++;
    n_checks++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: rd_data=%0d expected 0", rd_data);
    else n_pass++;
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: rd_valid=%b expected 0", rd_valid);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [NUM_CH-1:0] exp;
    drive_write('h10, 8'd0, 1'b1);
    sb_pulse.push_back(4'b0001);
    sb_pulse.push_back(4'b0000);
    sb_pulse.push_back(4'b0000);
    while (sb_pulse.size() > 0) begin
      tick();
      idle_inputs();
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL single: pulse_out=%b busy=%b expected %b", pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_retrigger();
    logic [NUM_CH-1:0] exp;
    drive_write('h12, 8'd5, 1'b1);
    repeat (6) sb_pulse.push_back(4'b0100);
    repeat (2) sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      if (k == 3) drive_write('h12, 8'd2, 1'b1);
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL retrigger cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [NUM_CH-1:0] exp;
    drive_write('h11, 8'd10, 1'b1);
    sb_pulse.push_back(4'b0010);
    repeat (3) sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      if (k == 1) drive_write('h11, 8'd0, 1'b0);
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL abort cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [NUM_CH-1:0] exp;
    drive_write('h0F, 8'd3, 1'b1);
    repeat (6) sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      if (k == 1) drive_write('h14, 8'd3, 1'b1);
      if (k == 2) drive_write('h00, 8'd3, 1'b1);
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL out_of_range cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_parallel();
    logic [NUM_CH-1:0] exp;
    drive_write('h10, 8'd2, 1'b1);
    sb_pulse.push_back(4'b0001);
    sb_pulse.push_back(4'b1001);
    sb_pulse.push_back(4'b1001);
    sb_pulse.push_back(4'b0000);
    sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      if (k == 1) drive_write('h13, 8'd1, 1'b1);
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL parallel cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    logic [NUM_CH-1:0] exp;
    drive_write('h11, 8'd255, 1'b1);
    repeat (256) sb_pulse.push_back(4'b0010);
    repeat (2) sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL max_len cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_CH-1:0] exp;
    drive_write('h13, 8'd255, 1'b1);
    repeat (4) sb_pulse.push_back(4'b1000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      idle_inputs();
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL reset_mid_pre cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pulse_out !== 4'b0000 || busy !== 4'b0000)
      $display("FAIL reset_mid_async: pulse_out=%b busy=%b expected 0000", pulse_out, busy);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) sb_pulse.push_back(4'b0000);
    for (int k = 1; sb_pulse.size() > 0; k++) begin
      tick();
      exp = sb_pulse.pop_front();
      n_checks++;
      if (pulse_out !== exp || busy !== exp)
        $display("FAIL reset_mid_post cycle %0d: pulse_out=%b busy=%b expected %b", k, pulse_out, busy, exp);
      else n_pass++;
    end
  endtask

`ifdef CFG_PULSE_BANK_READBACK_EN
  task automatic test_readback();
    logic [LW+1:0] exp;
    drive_write('h10, 8'd7, 1'b1);
    tick();
    idle_inputs();
    tick();
    rd_en   = 1'b1;
    addr_in = 'h10;
    sb_rd.push_back({1'b1, 8'd6, 1'b1});
    tick();
    idle_inputs();
    exp = sb_rd.pop_front();
    n_checks++;
    if ({rd_valid, rd_data} !== exp)
      $display("FAIL readback_active: valid/data=%b/%0d expected %b/%0d", rd_valid, rd_data, exp[LW+1], exp[LW:0]);
    else n_pass++;
    rd_en   = 1'b1;
    addr_in = 'h20;
    sb_rd.push_back({1'b1, 9'd0});
    tick();
    idle_inputs();
    exp = sb_rd.pop_front();
    n_checks++;
    if ({rd_valid, rd_data} !== exp)
      $display("FAIL readback_oor: valid/data=%b/%0d expected %b/%0d", rd_valid, rd_data, exp[LW+1], exp[LW:0]);
    else n_pass++;
    drive_write('h10, 8'd0, 1'b0);
    rd_en = 1'b1;
    sb_rd.push_back({1'b1, 8'd4, 1'b1});
    tick();
    idle_inputs();
    exp = sb_rd.pop_front();
    n_checks++;
    if ({rd_valid, rd_data} !== exp)
      $display("FAIL readback_prewrite: valid/data=%b/%0d expected %b/%0d", rd_valid, rd_data, exp[LW+1], exp[LW:0]);
    else n_pass++;
    n_checks++;
    if (pulse_out !== 4'b0000)
      $display("FAIL readback_abort: pulse_out=%b expected 0000", pulse_out);
    else n_pass++;
    sb_rd.push_back({1'b0, 9'd0});
    tick();
    exp = sb_rd.pop_front();
    n_checks++;
    if ({rd_valid, rd_data} !== exp)
      $display("FAIL readback_idle: valid/data=%b/%0d expected %b/%0d", rd_valid, rd_data, exp[LW+1], exp[LW:0]);
    else n_pass++;
  endtask
`else
  task automatic test_readback();
    logic [LW+1:0] exp;
    drive_write('h10, 8'd7, 1'b1);
    tick();
    idle_inputs();
    rd_en   = 1'b1;
    addr_in = 'h10;
    sb_rd.push_back({1'b0, 9'd0});
    sb_rd.push_back({1'b0, 9'd0});
    while (sb_rd.size() > 0) begin
      tick();
      exp = sb_rd.pop_front();
      n_checks++;
      if ({rd_valid, rd_data} !== exp)
        $display("FAIL readback_disabled: valid/data=%b/%0d expected %b/%0d", rd_valid, rd_data, exp[LW+1], exp[LW:0]);
      else n_pass++;
    end
    idle_inputs();
    n_checks++;
    if (pulse_out !== 4'b0001)
      $display("FAIL readback_disabled_pulse: pulse_out=%b expected 0001", pulse_out);
    else n_pass++;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    repeat (2) tick();
    test_retrigger();
    repeat (2) tick();
    test_abort();
    repeat (2) tick();
    test_out_of_range();
    repeat (2) tick();
    test_parallel();
    repeat (2) tick();
    test_max_len();
    repeat (2) tick();
    test_reset_mid();
    repeat (2) tick();
    test_readback();
    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_pulse_bank.md
CFG_PULSE_BANK -- requirements
Module: cfg_pulse_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of pulse channels (1..32).
REQ-002 SHALL have parameter REG_BASE, default 0, address of channel 0; channel i at REG_BASE+i.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 8, address bus width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, width of pulse-length field.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: write_en  in  1  write strobe; addr_in  in  REG_ADDR_WIDTH  write/read address; data_in  in  LEN_WIDTH+1  bit0 = set, bits[LEN_WIDTH:1] = length.
REQ-007 SHALL have ports: rd_en  in  1  read strobe; rd_data  out  LEN_WIDTH+1  {remaining count, busy}; rd_valid  out  1  read-data qualifier.
REQ-008 SHALL have ports: pulse_out  out  NUM_CH  per-channel pulse; busy  out  NUM_CH  per-channel active flag.

Function
REQ-009 Write hit SHALL be write_en=1 and REG_BASE <= addr_in < REG_BASE+NUM_CH; channel index = addr_in-REG_BASE; other addresses SHALL be ignored.
REQ-010 Hit with set=1 on idle channel SHALL move it IDLE->ACTIVE; cycle N write gives pulse_out[i]=1 from cycle N+1 for length+1 cycles (length 0 = 1 cycle, max 2^LEN_WIDTH cycles).
REQ-011 Per-channel states SHALL be IDLE (pulse 0, count 0) and ACTIVE (pulse 1); ACTIVE->IDLE when count reaches 0 at end of final cycle.
REQ-012 Hit with set=1 on ACTIVE channel SHALL retrigger: count reloads with new length, pulse stays high without a gap.
REQ-013 Hit with set=0 SHALL abort: channel returns to IDLE next cycle, pulse deasserts from cycle N+1.
REQ-014 busy[i] SHALL equal pulse_out[i]; both registered outputs.
REQ-015 Count SHALL be LEN_WIDTH bits, decrement saturating at 0, never wrap.
REQ-016 Only one channel SHALL be affected per cycle; channels otherwise run independently and simultaneous expiries are allowed.
REQ-017 Read: rd_en=1 in cycle N SHALL give rd_valid=1 and rd_data for addr_in in cycle N+1; out-of-range read returns 0 with rd_valid=1.
REQ-018 Simultaneous read and write to same channel SHALL return pre-write state.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all channels to IDLE, count 0, pulse_out=0, busy=0, rd_data=0, rd_valid=0.
REQ-020 Reset mid-pulse SHALL terminate the pulse immediately; no pulse SHALL resume after release.

Configuration
REQ-021 Macro CFG_PULSE_BANK_READBACK_EN defined: read path per REQ-017/018 present.
REQ-022 Macro undefined: no read logic; rd_data and rd_valid tied 0; rd_en ignored; pulse behaviour unchanged.

Structure
REQ-023 Shared package cfg_pkg SHALL hold channel state encoding (IDLE/ACTIVE) and data_in field offsets (SET_BIT=0, LEN_LSB=1).
REQ-024 One sub-module cfg_pulse_chan (single-channel FSM + counter) SHALL be instantiated NUM_CH times via generate; top holds decode and read mux.

Verification
REQ-025 NUM_CH=4, REG_BASE=0x10: write 0x10 data set=1 len=0 -> pulse_out[0] high exactly 1 cycle, starting next cycle.
REQ-026 Write 0x12 len=5, then at 3rd pulse cycle write 0x12 len=2 -> pulse_out[2] continuous, total 3+3=6 cycles.
REQ-027 Write 0x11 len=10, next cycle write 0x11 set=0 -> pulse_out[1] high exactly 1 cycle.
REQ-028 Write 0x13 len=255, assert rst_n=0 after 4 cycles -> pulse_out and busy drop asynchronously, stay 0 after release.
REQ-029 With READBACK_EN: write 0x10 len=7, read 0x10 two cycles later -> rd_valid next cycle, rd_data = {6,1}; read 0x20 -> 0.
REQ-030 Writes to 0x0F and 0x14 -> no pulse_out activity on any channel.
